// File: rtl/arm_div_unit_pkg.sv
// Shared definitions for the sequential divider: FSM states and ALU flag bit positions.
package arm_div_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // C and V are always clear for divide results.
  function automatic logic [3:0] make_flags(input logic n, input logic z);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/arm_div_unit_if.sv
// Request/result bundle between the control FSM (master) and the divider (slave).
interface arm_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic [3:0]       ALUFlags;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, quotient, remainder, div_zero, ALUFlags
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, quotient, remainder, div_zero, ALUFlags
  );
endinterface

// File: rtl/arm_div_step.sv
// One radix-2 restoring iteration: shift {rem,dvd} left, trial-subtract, shift in the quotient bit.
module arm_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // With rem < divisor, the top bit of the WIDTH+1-bit difference is a clean borrow.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], ~trial[WIDTH]};
  end
endmodule

// File: rtl/arm_div_unit.sv
// Multicycle UDIV/SDIV unit: fixed-latency restoring divider with sign fix-up and held results.
module arm_div_unit
  import arm_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  arm_div_unit_if.slave  div
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, dvd_q, dvs_q, a_q;
  logic             sign_q_q, sign_r_q;
  logic [WIDTH-1:0] a_mag, b_mag, rem_n, dvd_n, q_fix, r_fix;
  logic [WIDTH-1:0] quot_q, remo_q;
  logic             dz_q;
  logic [3:0]       flags_q;

  arm_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (dvs_q),
    .rem_next (rem_n),
    .dvd_next (dvd_n)
  );

  always_comb begin
    a_mag = (div.is_signed && div.a[WIDTH-1]) ? -div.a : div.a;
    b_mag = (div.is_signed && div.b[WIDTH-1]) ? -div.b : div.b;
  end

  // Zero divisor overrides the iteration result, which is meaningless in that case.
  always_comb begin
    q_fix = sign_q_q ? -dvd_q : dvd_q;
    r_fix = sign_r_q ? -rem_q : rem_q;
    if (dvs_q == '0) begin
      q_fix = '0;
      r_fix = a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (div.start) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      quot_q   <= '0;
      remo_q   <= '0;
      dz_q     <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (div.start) begin
          a_q      <= div.a;
          dvd_q    <= a_mag;
          dvs_q    <= b_mag;
          rem_q    <= '0;
          cnt_q    <= CW'(WIDTH - 1);
          sign_q_q <= div.is_signed & (div.a[WIDTH-1] ^ div.b[WIDTH-1]);
          sign_r_q <= div.is_signed & div.a[WIDTH-1];
        end
        S_CALC: begin
          rem_q <= rem_n;
          dvd_q <= dvd_n;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          quot_q  <= q_fix;
          remo_q  <= r_fix;
          dz_q    <= (dvs_q == '0);
          flags_q <= make_flags(q_fix[WIDTH-1], q_fix == '0);
        end
        default: ;
      endcase
    end
  end

  assign div.busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign div.done      = (state_q == S_DONE);
  assign div.quotient  = quot_q;
  assign div.remainder = remo_q;
  assign div.div_zero  = dz_q;
  assign div.ALUFlags  = flags_q;
endmodule
